// File: rtl/trig_core.sv
// Hysteresis threshold trigger with pre/post window extension and ADC saturation flag.
// Optional macro TRIG_SAT_HOLD_EN: hold SATURATION_FLAG until the trigger window closes.
module trig_core #(
  parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int MAX_POST_ACQUISITION_LENGTH = 2,
  localparam int DATA_W     = 16,
  localparam int SAMPLE_NUM = 8,
  localparam int ADC_W      = 12,
  localparam int TDATA_W    = DATA_W * SAMPLE_NUM,
  localparam int PRE_W      = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1,
  localparam int POST_W     = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     SET_CONFIG,
  input  logic                     STOP,
  input  logic [TDATA_W-1:0]       S_AXIS_TDATA,
  input  logic                     S_AXIS_TVALID,
  input  logic [TDATA_W-1:0]       H_S_AXIS_TDATA,
  input  logic signed [DATA_W-1:0] RISING_EDGE_THRSHOLD,
  input  logic signed [DATA_W-1:0] FALLING_EDGE_THRESHOLD,
  input  logic [PRE_W-1:0]         PRE_ACQUISITION_LENGTH,
  input  logic [POST_W-1:0]        POST_ACQUISITION_LENGTH,
  output logic                     TRIGGER,
  output logic                     SATURATION_FLAG
);

  localparam int CNT_W = $clog2(MAX_PRE_ACQUISITION_LENGTH + MAX_POST_ACQUISITION_LENGTH + 1);

  function automatic logic any_gt(input logic [TDATA_W-1:0] d, input logic signed [DATA_W-1:0] th);
    logic r;
    r = 1'b0;
    for (int i = 0; i < SAMPLE_NUM; i++)
      if ($signed(d[DATA_W*i +: DATA_W]) > th) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_ge(input logic [TDATA_W-1:0] d, input logic signed [DATA_W-1:0] th);
    logic r;
    r = 1'b0;
    for (int i = 0; i < SAMPLE_NUM; i++)
      if ($signed(d[DATA_W*i +: DATA_W]) >= th) r = 1'b1;
    return r;
  endfunction

  // ADC code sits in the top 12 bits of each 16-bit raw lane; full-scale codes mean clipping.
  function automatic logic any_sat(input logic [TDATA_W-1:0] d);
    logic [ADC_W-1:0] code;
    logic             r;
    r = 1'b0;
    for (int i = 0; i < SAMPLE_NUM; i++) begin
      code = d[DATA_W*i + (DATA_W-ADC_W) +: ADC_W];
      if (code == 12'h7FF || code == 12'h800) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_len(input int v, input int max_len);
    return (v > max_len) ? CNT_W'(max_len) : CNT_W'(v);
  endfunction

  logic             over_p0, over_p1, trig_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             sat_p0, sat_p1, sat_p2;

  logic             gt_in, ge_in, sat_in, over_nxt, trig_nxt, flag_nxt;
  logic [CNT_W-1:0] len, cnt_nxt;
  logic [4*SAMPLE_NUM-1:0] h_unused_nib;

  always_comb begin
    h_unused_nib = '0;
    for (int i = 0; i < SAMPLE_NUM; i++)
      h_unused_nib[4*i +: 4] = H_S_AXIS_TDATA[DATA_W*i +: 4];
  end

  always_comb begin
    gt_in  = S_AXIS_TVALID && any_gt(S_AXIS_TDATA, RISING_EDGE_THRSHOLD);
    ge_in  = S_AXIS_TVALID && any_ge(S_AXIS_TDATA, FALLING_EDGE_THRESHOLD);
    sat_in = S_AXIS_TVALID && any_sat(H_S_AXIS_TDATA);
    // STOP only blocks a new arm; an active state keeps running on the falling threshold.
    over_nxt = (gt_in && !STOP) || (over_p0 && ge_in);

    len = clamp_len(int'(PRE_ACQUISITION_LENGTH),  MAX_PRE_ACQUISITION_LENGTH)
        + clamp_len(int'(POST_ACQUISITION_LENGTH), MAX_POST_ACQUISITION_LENGTH);

    trig_nxt = 1'b0;
    cnt_nxt  = '0;
    if (over_p1) begin
      trig_nxt = 1'b1;
      cnt_nxt  = len;
    end else if (cnt_p2 != '0) begin
      trig_nxt = 1'b1;
      cnt_nxt  = cnt_p2 - CNT_W'(1);
    end

`ifdef TRIG_SAT_HOLD_EN
    flag_nxt = sat_p1 || (sat_p2 && trig_nxt);
`else
    flag_nxt = sat_p1;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || SET_CONFIG) begin
      over_p0 <= 1'b0;
      over_p1 <= 1'b0;
      trig_p2 <= 1'b0;
      cnt_p2  <= '0;
      sat_p0  <= 1'b0;
      sat_p1  <= 1'b0;
      sat_p2  <= 1'b0;
    end else begin
      // p0: threshold state and raw saturation
      over_p0 <= over_nxt;
      sat_p0  <= sat_in;
      // p1: alignment delay
      over_p1 <= over_p0;
      sat_p1  <= sat_p0;
      // p2: window extension and output flags
      trig_p2 <= trig_nxt;
      cnt_p2  <= cnt_nxt;
      sat_p2  <= flag_nxt;
    end
  end

  assign TRIGGER         = trig_p2;
  assign SATURATION_FLAG = sat_p2;

endmodule

// File: tb/tb_trig_core.sv
// Bench for trig_core: directed vector table plus randomized run against a window-based model.
module tb_trig_core;

  localparam int MAXP = 2;
  localparam int NMAX = 4096;

  logic         ACLK = 1'b0;
  logic         ARESET, SET_CONFIG, STOP, S_AXIS_TVALID;
  logic [127:0] S_AXIS_TDATA, H_S_AXIS_TDATA;
  logic signed [15:0] RISING_EDGE_THRSHOLD, FALLING_EDGE_THRESHOLD;
  logic [1:0]   PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH;
  logic         TRIGGER, SATURATION_FLAG;

  trig_core #(.MAX_PRE_ACQUISITION_LENGTH(2), .MAX_POST_ACQUISITION_LENGTH(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .SET_CONFIG(SET_CONFIG), .STOP(STOP),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .H_S_AXIS_TDATA(H_S_AXIS_TDATA),
    .RISING_EDGE_THRSHOLD(RISING_EDGE_THRSHOLD), .FALLING_EDGE_THRESHOLD(FALLING_EDGE_THRESHOLD),
    .PRE_ACQUISITION_LENGTH(PRE_ACQUISITION_LENGTH), .POST_ACQUISITION_LENGTH(POST_ACQUISITION_LENGTH),
    .TRIGGER(TRIGGER), .SATURATION_FLAG(SATURATION_FLAG)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: per-cycle over/sat history, indexed by input cycle
  bit ov [0:NMAX-1];
  bit sv [0:NMAX-1];
  int cyc = 0;
  int rst_at = -1;
  bit started = 0;
  bit m_over = 0;
  bit m_flag = 0;

  task automatic check(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", nm, cyc, act, exp);
    end
  endtask

  function automatic int clampm(input int v);
    return (v > MAXP) ? MAXP : v;
  endfunction

  // Apply the current inputs for one clock, advance the model, compare outputs of the next cycle.
  task automatic tick();
    int  n, t, len, k;
    bit  gt, ge, st, e_trig, e_sat;
    logic signed [15:0] s;
    logic [11:0] code;
    n = cyc;
    if (ARESET || SET_CONFIG) begin
      rst_at = n; ov[n] = 0; sv[n] = 0; m_over = 0; started = 1;
    end else begin
      gt = 0; ge = 0; st = 0;
      if (S_AXIS_TVALID) begin
        for (int i = 0; i < 8; i++) begin
          s = $signed(S_AXIS_TDATA[16*i +: 16]);
          if (s > RISING_EDGE_THRSHOLD) gt = 1;
          if (s >= FALLING_EDGE_THRESHOLD) ge = 1;
          code = H_S_AXIS_TDATA[16*i+4 +: 12];
          if (code == 12'h7FF || code == 12'h800) st = 1;
        end
      end
      if (!m_over) m_over = gt && !STOP;
      else         m_over = ge;
      ov[n] = m_over; sv[n] = st;
    end
    len = clampm(int'(PRE_ACQUISITION_LENGTH)) + clampm(int'(POST_ACQUISITION_LENGTH));
    @(posedge ACLK); #1;
    cyc = n + 1;
    t = n + 1;
    e_trig = 0;
    for (k = t - 3 - len; k <= t - 3; k++)
      if (k > rst_at && k >= 0 && ov[k]) e_trig = 1;
    e_sat = (t - 3 > rst_at && t - 3 >= 0) ? sv[t-3] : 1'b0;
`ifdef TRIG_SAT_HOLD_EN
    if (m_flag && e_trig) e_sat = 1;
`endif
    m_flag = e_sat;
    if (started) begin
      check("model_trigger", TRIGGER, e_trig);
      check("model_satflag", SATURATION_FLAG, e_sat);
    end
  endtask

  task automatic drive(input logic signed [15:0] v0, input logic signed [15:0] fill,
                       input logic stp, input logic vld, input logic sat);
    S_AXIS_TDATA = {fill, fill, fill, fill, fill, fill, fill, v0};
    S_AXIS_TVALID = vld;
    STOP = stp;
    H_S_AXIS_TDATA = '0;
    if (sat) H_S_AXIS_TDATA[16*3+4 +: 12] = 12'h7FF;
  endtask

  typedef struct {
    string              name;
    logic signed [15:0] rise, fall, fill;
    logic [1:0]         pre, post;
    logic [63:0]        seq;      // lane-0 value for cycle c+i at [16i +: 16]
    logic [3:0]         stop_m, inval_m, sat_m;
    logic [10:0]        trig_e, sat_e;  // bit j: output during cycle c+j
  } vec_t;

  function automatic vec_t mkv(input string nm, input int rise, input int fall, input int fill,
                               input int pre, input int post, input int a, input int b,
                               input int c, input int d, input logic [3:0] stp, input logic [3:0] inv,
                               input logic [3:0] sat, input logic [10:0] te, input logic [10:0] se);
    vec_t v;
    v.name = nm; v.rise = 16'(rise); v.fall = 16'(fall); v.fill = 16'(fill);
    v.pre = 2'(pre); v.post = 2'(post);
    v.seq = {16'(d), 16'(c), 16'(b), 16'(a)};
    v.stop_m = stp; v.inval_m = inv; v.sat_m = sat; v.trig_e = te; v.sat_e = se;
    return v;
  endfunction

  vec_t vt [11];

  initial begin
    logic [10:0] hold_e;
    logic signed [15:0] cur;
    int base;
    logic [127:0] hd;

`ifdef TRIG_SAT_HOLD_EN
    hold_e = 11'h038;
`else
    hold_e = 11'h008;
`endif
    vt[0]  = mkv("single",    1024, 1024,     0, 1, 1, 1500, 0, 0, 0,       4'h0, 4'h0, 4'h0, 11'h038, 11'h000);
    vt[1]  = mkv("hyst",      1024,  512,     0, 0, 0, 1500, 800, 800, 100, 4'h0, 4'h0, 4'h0, 11'h038, 11'h000);
    vt[2]  = mkv("sat",       1024, 1024,     0, 0, 0, 0, 0, 0, 0,          4'h0, 4'h0, 4'h1, 11'h000, 11'h008);
    vt[3]  = mkv("stop",      1024, 1024,     0, 1, 1, 1500, 0, 0, 0,       4'hF, 4'h0, 4'h0, 11'h000, 11'h000);
    vt[4]  = mkv("clamp",     1024, 1024,     0, 3, 3, 1500, 0, 0, 0,       4'h0, 4'h0, 4'h0, 11'h0F8, 11'h000);
    vt[5]  = mkv("nowin",     1024, 1024,     0, 0, 0, 1500, 0, 0, 0,       4'h0, 4'h0, 4'h0, 11'h008, 11'h000);
    vt[6]  = mkv("merge",     1024, 1024,     0, 1, 0, 1500, 0, 1500, 0,    4'h0, 4'h0, 4'h0, 11'h078, 11'h000);
    vt[7]  = mkv("negative",  -100, -200, -1000, 0, 0, -50, -150, -300, -300, 4'h0, 4'h0, 4'h0, 11'h018, 11'h000);
    vt[8]  = mkv("stop_mid",  1024, 1024,     0, 0, 1, 1500, 1100, 0, 0,    4'hE, 4'h0, 4'h0, 11'h038, 11'h000);
    vt[9]  = mkv("invalid",   1024, 1024,     0, 1, 1, 1500, 0, 0, 0,       4'h0, 4'h1, 4'h1, 11'h000, 11'h000);
    vt[10] = mkv("sat_win",   1024, 1024,     0, 1, 1, 1500, 0, 0, 0,       4'h0, 4'h0, 4'h1, 11'h038, hold_e);

    ARESET = 1; SET_CONFIG = 0;
    RISING_EDGE_THRSHOLD = 16'sd1024; FALLING_EDGE_THRESHOLD = 16'sd1024;
    PRE_ACQUISITION_LENGTH = 2'd1; POST_ACQUISITION_LENGTH = 2'd1;
    drive(16'sd1500, 16'sd1500, 1'b0, 1'b1, 1'b1);
    #1;

    // reset holds outputs low even with triggering/saturating input
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_trigger", TRIGGER, 1'b0);
      check("reset_satflag", SATURATION_FLAG, 1'b0);
    end
    ARESET = 0;

    foreach (vt[v]) begin
      RISING_EDGE_THRSHOLD = vt[v].rise; FALLING_EDGE_THRESHOLD = vt[v].fall;
      PRE_ACQUISITION_LENGTH = vt[v].pre; POST_ACQUISITION_LENGTH = vt[v].post;
      SET_CONFIG = 1;
      drive(vt[v].fill, vt[v].fill, 1'b0, 1'b1, 1'b0);
      tick();
      SET_CONFIG = 0;
      for (int j = 0; j < 10; j++) begin
        if (j < 4) begin
          cur = vt[v].seq[16*j +: 16];
          drive(cur, vt[v].fill, vt[v].stop_m[j], !vt[v].inval_m[j], vt[v].sat_m[j]);
        end else begin
          drive(vt[v].fill, vt[v].fill, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check({"vec_", vt[v].name, "_trigger"}, TRIGGER, vt[v].trig_e[j+1]);
        check({"vec_", vt[v].name, "_satflag"}, SATURATION_FLAG, vt[v].sat_e[j+1]);
      end
    end

    // SET_CONFIG in the middle of a window clears TRIGGER on the next clock
    RISING_EDGE_THRSHOLD = 16'sd1024; FALLING_EDGE_THRESHOLD = 16'sd1024;
    PRE_ACQUISITION_LENGTH = 2'd1; POST_ACQUISITION_LENGTH = 2'd1;
    SET_CONFIG = 1; drive(16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0); tick();
    SET_CONFIG = 0; drive(16'sd1500, 16'sd0, 1'b0, 1'b1, 1'b0); tick();
    drive(16'sd0, 16'sd0, 1'b0, 1'b1, 1'b0); tick(); tick();
    check("cfg_mid_active", TRIGGER, 1'b1);
    SET_CONFIG = 1; tick();
    check("cfg_mid_cleared", TRIGGER, 1'b0);
    SET_CONFIG = 0; tick();
    check("cfg_mid_stays_low", TRIGGER, 1'b0);

    // randomized run; lengths/thresholds only change together with SET_CONFIG
    for (int r = 0; r < 1500; r++) begin
      SET_CONFIG = 0; ARESET = 0;
      if (r % 150 == 0) begin
        base = int'($urandom_range(0, 4000)) - 2000;
        RISING_EDGE_THRSHOLD = 16'(base);
        FALLING_EDGE_THRESHOLD = 16'(base - int'($urandom_range(0, 1500)));
        PRE_ACQUISITION_LENGTH = 2'($urandom_range(0, 3));
        POST_ACQUISITION_LENGTH = 2'($urandom_range(0, 3));
        SET_CONFIG = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        ARESET = 1;
      end
      base = int'($urandom_range(0, 8000)) - 4000;
      for (int i = 0; i < 8; i++)
        S_AXIS_TDATA[16*i +: 16] = 16'(base + int'($urandom_range(0, 400)) - 200);
      hd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 19) == 0)
        hd[16*$urandom_range(0, 7) + 4 +: 12] = $urandom_range(0, 1) ? 12'h7FF : 12'h800;
      H_S_AXIS_TDATA = hd;
      S_AXIS_TVALID = ($urandom_range(0, 9) != 0);
      STOP = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
